// File: rtl/mg_div16u_pkg.sv
// mg_div_pkg: shared width, counter width and FSM state encoding for the divider
package mg_div_pkg;
  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mg_div16u_if.sv
// mg_div16u_if: operand/result valid-ready bundle between a requester and the divider
interface mg_div16u_if;
  import mg_div_pkg::*;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/mg_div16u_sub.sv
// mg_sub: ripple-borrow subtractor a - b as a + ~b + 1; nborrow is the carry-out (1 when a >= b)
module mg_sub #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         nborrow
);
  logic [N:0]   c;
  logic [N-1:0] p;
  logic [N-1:0] g;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign p[i]    = a[i] ^ ~b[i];
    assign g[i]    = a[i] & ~b[i];
    assign c[i+1]  = g[i] | (p[i] & c[i]);
    assign diff[i] = p[i] ^ c[i];
  end
  assign nborrow = c[N];
endmodule

// File: rtl/mg_div16u.sv
// mg_div16u: sequential restoring unsigned divider, one quotient bit per cycle
module mg_div16u
  import mg_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  mg_div16u_if.slave  bus
);
  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic             dbz_r;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] q_nx;
  logic             nb;
  // The partial remainder stays below the divisor, so its top bit is only needed in the trial value
  assign shifted = {1'b0, rem, q[WIDTH-1]};
  mg_sub #(.N(WIDTH + 1)) u_sub (
    .a       (shifted),
    .b       ({1'b0, dsr}),
    .diff    (diff),
    .nborrow (nb)
  );
  always_comb begin
    rem_nx = nb ? diff : shifted;
    q_nx   = {q[WIDTH-2:0], nb};
  end
  assign bus.in_ready    = state == S_IDLE;
  assign bus.out_valid   = state == S_DONE;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      q     <= '0;
      dsr   <= '0;
      rem   <= '0;
      cnt   <= '0;
      quo_r <= '0;
      rem_r <= '0;
      dbz_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          q   <= bus.dividend;
          dsr <= bus.divisor;
          rem <= '0;
          cnt <= CNT_W'(WIDTH);
          if (bus.divisor == '0) begin
            quo_r <= '1;
            rem_r <= bus.dividend;
            dbz_r <= 1'b1;
            state <= S_DONE;
          end else begin
            dbz_r <= 1'b0;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          rem <= rem_nx[WIDTH-1:0];
          q   <= q_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            quo_r <= q_nx;
            rem_r <= rem_nx[WIDTH-1:0];
            state <= S_DONE;
          end
        end
        S_DONE: if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mg_div16u.sv
// tb_mg_div16u: directed and randomized checks of the sequential divider
module tb_mg_div16u;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  mg_div16u_if bus ();
  mg_div16u dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                       output logic [15:0] q, output logic [15:0] r, output logic z, output int lat);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    if (hold > 0) begin
      bus.out_ready = 1'b0;
      repeat (hold) begin @(posedge clk); #1; end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {2'b10, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b q=%h r=%h z=%b, want rdy=1 vld=0 q=0 r=0 z=0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_basic;
    logic [15:0] q, r;
    logic z;
    int lat;
    do_op(16'd100, 16'd7, 0, q, r, z, lat);
    checks++;
    if ({q, r, z} !== {16'd14, 16'd2, 1'b0}) begin
      errors++;
      $display("FAIL basic 100/7: q=%0d r=%0d z=%b, want q=14 r=2 z=0", q, r, z);
    end
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL basic latency: %0d, want 17", lat);
    end
  endtask
  task automatic test_extremes;
    logic [15:0] tv [4][4] = '{'{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000},
                               '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000},
                               '{16'd3,    16'd10,   16'd0,    16'd3},
                               '{16'd1,    16'd1,    16'd1,    16'd0}};
    logic [15:0] q, r;
    logic z;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(tv[i][0], tv[i][1], 0, q, r, z, lat);
      checks++;
      if ({q, r, z, lat} !== {tv[i][2], tv[i][3], 1'b0, 32'd17}) begin
        errors++;
        $display("FAIL extreme %h/%h: q=%h r=%h z=%b lat=%0d, want q=%h r=%h z=0 lat=17",
                 tv[i][0], tv[i][1], q, r, z, lat, tv[i][2], tv[i][3]);
      end
    end
  endtask
  task automatic test_div_by_zero;
    logic [15:0] q, r;
    logic z;
    int lat;
    do_op(16'd5, 16'd0, 0, q, r, z, lat);
    checks++;
    if ({q, r, z} !== {16'hFFFF, 16'd5, 1'b1}) begin
      errors++;
      $display("FAIL div0 5/0: q=%h r=%0d z=%b, want q=ffff r=5 z=1", q, r, z);
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL div0 latency: %0d, want 1", lat);
    end
  endtask
  task automatic test_backpressure;
    int n = 0;
    bus.out_ready    = 1'b0;
    bus.in_valid     = 1'b1;
    bus.dividend     = 16'd200;
    bus.divisor      = 16'd9;
    @(posedge clk); #1;
    bus.dividend     = 16'd9;
    bus.divisor      = 16'd4;
    while (!bus.out_valid && n < 40) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero} !== {2'b10, 16'd22, 16'd2, 1'b0}) begin
        errors++;
        $display("FAIL backpressure cycle %0d: vld=%b rdy=%b q=%0d r=%0d z=%b, want vld=1 rdy=0 q=22 r=2 z=0",
                 i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_by_zero);
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure release: vld=%b rdy=%b, want vld=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask
  task automatic test_reset_mid;
    logic [15:0] q, r;
    logic z;
    int lat;
    bus.in_valid = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero} !== {2'b10, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset mid-calc: rdy=%b vld=%b q=%h r=%h z=%b, want rdy=1 vld=0 q=0 r=0 z=0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_op(16'd1000, 16'd3, 0, q, r, z, lat);
    checks++;
    if ({q, r, z, lat} !== {16'd333, 16'd1, 1'b0, 32'd17}) begin
      errors++;
      $display("FAIL after reset 1000/3: q=%0d r=%0d z=%b lat=%0d, want q=333 r=1 z=0 lat=17", q, r, z, lat);
    end
  endtask
  task automatic test_random;
    logic [15:0] a, b, q, r, eq, er;
    logic z;
    int lat;
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = (i % 4 == 0) ? 16'($urandom_range(1, 15)) : (i % 37 == 5) ? 16'd0 : 16'($urandom_range(0, 65535));
      eq = (b == 0) ? 16'hFFFF : a / b;
      er = (b == 0) ? a : a % b;
      do_op(a, b, (i % 2) ? int'($urandom_range(0, 3)) : 0, q, r, z, lat);
      checks++;
      if ({q, r, z, lat} !== {eq, er, b == 0, (b == 0) ? 32'd1 : 32'd17}) begin
        errors++;
        $display("FAIL random %0d/%0d: q=%0d r=%0d z=%b lat=%0d, want q=%0d r=%0d z=%b", a, b, q, r, z, lat, eq, er, b == 0);
      end
      if (b != 0) begin
        checks++;
        if (32'(q) * 32'(b) + 32'(r) != 32'(a) || r >= b) begin
          errors++;
          $display("FAIL random identity %0d/%0d: q=%0d r=%0d", a, b, q, r);
        end
      end
    end
  endtask
  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    test_reset;
    test_basic;
    test_extremes;
    test_div_by_zero;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
